// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures each period of an asynchronous clock in reference-clock cycles,
// tracks min/max, checks a period window and flags loss of clock. CLK_MON_DUTY_EN adds high-time capture.
module clk_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] exp_min,
  input  logic [CNT_W-1:0] exp_max,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic             out_of_range,
  output logic [7:0]       err_cnt,
  output logic             lost,
  output logic [CNT_W-1:0] high_time
);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, RUN, LOST} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   sync;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   sample;
  logic                   in_window;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sync      = sync_q[SYNC_STAGES-1];
  assign edge_det  = sync && !sync_d;
  assign in_window = (cnt >= exp_min) && (cnt <= exp_max);
  assign lost      = (state == LOST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = sat_inc(cnt);
    sample    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          cnt_nxt   = '0;
        end
        ARM, LOST: begin
          if (edge_det) begin
            state_nxt = RUN;
            cnt_nxt   = CNT_W'(1);
          end else if (state == ARM && cnt == TIMEOUT_C) begin
            state_nxt = LOST;
          end
        end
        RUN: begin
          // An edge coinciding with the timeout is a valid period, not a loss.
          if (edge_det) begin
            sample  = 1'b1;
            cnt_nxt = CNT_W'(1);
          end else if (cnt == TIMEOUT_C) begin
            state_nxt = LOST;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sync_q       <= '0;
      sync_d       <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_vld   <= 1'b0;
      period_min   <= CNT_MAX;
      period_max   <= '0;
      out_of_range <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state      <= state_nxt;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      sync_d     <= sync;
      cnt        <= cnt_nxt;
      period_vld <= sample;
      if (sample) period <= cnt;
      // A sample landing with clr is reported but not folded into the fresh statistics.
      if (clr) begin
        period_min   <= CNT_MAX;
        period_max   <= '0;
        out_of_range <= 1'b0;
        err_cnt      <= '0;
      end else if (sample) begin
        if (cnt < period_min) period_min <= cnt;
        if (cnt > period_max) period_max <= cnt;
        if (!in_window) begin
          out_of_range <= 1'b1;
          err_cnt      <= sat_inc8(err_cnt);
        end
      end
    end
  end

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hcnt;

  // hcnt restarts at 1 on the edge because the edge cycle itself is a high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      if (!en)           hcnt <= '0;
      else if (edge_det) hcnt <= CNT_W'(1);
      else if (sync)     hcnt <= sat_inc(hcnt);
      if (sample) high_time <= hcnt;
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: doc/clk_period_monitor.md
# clk_period_monitor

- Synthesizable monitor for a clock under test, such as a generated clock with frequency, duty cycle and jitter settings.
- Measures each period of asynchronous input `mon_clk` in cycles of the local reference clock `clk`.
- Tracks min/max period, checks each period against a programmable window, and flags loss of clock.
- Sits directly downstream of the clock source; its outputs feed status registers and frequency-check benches.

## Interface
- `CNT_W`, 16, width of period counter and all period-valued ports
- `SYNC_STAGES`, 2, synchronizer depth for `mon_clk` (≥2)
- `TIMEOUT`, 4096, `clk` cycles without a `mon_clk` edge before loss is declared (must be < 2^CNT_W − 1)
- `clk` input 1: reference clock; all logic on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `en` input 1: monitor enable (level)
- `clr` input 1: single-cycle pulse; clears statistics
- `mon_clk` input 1: clock under test, asynchronous to `clk`
- `exp_min` input CNT_W: lowest acceptable period, inclusive
- `exp_max` input CNT_W: highest acceptable period, inclusive
- `period` output CNT_W: last measured period in `clk` cycles
- `period_vld` output 1: one-cycle pulse when `period` updates
- `period_min` output CNT_W: smallest period since reset/clr
- `period_max` output CNT_W: largest period since reset/clr
- `out_of_range` output 1: sticky; a period fell outside [exp_min, exp_max]
- `err_cnt` output 8: count of out-of-range periods, saturating at 255
- `lost` output 1: level; high while in LOST
- `high_time` output CNT_W: `clk` cycles the synced `mon_clk` was high during the last period (see Configuration)

## Operation
- `mon_clk` passes through a SYNC_STAGES flop chain, then a rising-edge detector (`edge` = sync && !sync_d).
- Counter `cnt` loads 1 on `edge`, otherwise increments, saturating at all-ones. At an edge, `cnt` equals the edge-to-edge distance in `clk` cycles.
- FSM states:
  - IDLE: `cnt`=0, no outputs change. Entered from any state when `en`=0. `en`=1 → ARM.
  - ARM: waits for first `edge`, with no measurement. `edge` → RUN and `cnt`←1. `cnt`==TIMEOUT → LOST.
  - RUN: on `edge`:
    - `period`←`cnt` and `period_vld`=1.
    - min/max update.
    - Window check: if `cnt`<`exp_min` or `cnt`>`exp_max`, then `out_of_range`←1 and `err_cnt`+1 (saturating).
    - `cnt`==TIMEOUT with no edge → LOST.
  - LOST: `lost`=1. `edge` → RUN with `cnt`←1. That first edge produces no `period_vld`.
- `clr`:
  - Sets `period_min`←all-ones, `period_max`←0, `out_of_range`←0, `err_cnt`←0.
  - If coincident with an edge in RUN, `period`/`period_vld` still update, but that sample is not folded into min/max/range/err_cnt.
- `clr` does not change FSM state, `period`, or `lost`.
- Deasserting `en` mid-period drops to IDLE. The partial period is discarded, and statistics and `period` are held.

## Timing
- Reset values:
  - `period`=0, `period_vld`=0
  - `period_min`=all-ones, `period_max`=0
  - `out_of_range`=0, `err_cnt`=0, `lost`=0, `high_time`=0
  - FSM=IDLE, `cnt`=0, synchronizer=0
- Latency from a `mon_clk` rising edge to `period_vld`: SYNC_STAGES+1 `clk` cycles, ±1 cycle of sampling uncertainty.
- Stats and flags are all registered and update in the same cycle `period_vld` is high.
- `lost` rises the cycle after `cnt` reaches TIMEOUT. It falls the cycle after the next detected edge.
- Resolution is one `clk` period. Periods below 2 `clk` cycles are not measurable: `mon_clk` must be < `clk`/2.
- `edge` and `cnt`==TIMEOUT in the same cycle: the edge wins and no LOST entry occurs.

## Configuration
- `CLK_MON_DUTY_EN` defined:
  - Counter `hcnt` counts cycles with synced `mon_clk` high and resets on `edge`.
  - `high_time`←`hcnt` at each `period_vld`.
- `CLK_MON_DUTY_EN` undefined: `hcnt` logic is absent and `high_time` is tied to 0. The port list is unchanged.

## Test plan
- `clk`=10 ns, `mon_clk`=40 ns (50% duty), `en`=1, window [4,4] → after first edge, every `period_vld` shows `period`=4; min=max=4; `out_of_range`=0.
- `mon_clk` alternates 30 ns/50 ns, window [4,4] → periods 3/5; min=3, max=5; `out_of_range`=1; `err_cnt` increments per sample and saturates at 255.
- Stop `mon_clk` with TIMEOUT=64 → `lost`=1 at 65 cycles after last edge. Restart at 40 ns → first edge gives no `period_vld`, second gives `period`=4, `lost`=0.
- `clr` pulsed in the same cycle as `period_vld` → `period` updates; `period_min`=all-ones, `period_max`=0, `err_cnt`=0 the following cycle.
- Deassert `en` mid-period, then `rst_n` low mid-RUN → IDLE with stats held. Then every output returns to its reset value asynchronously.
- With `CLK_MON_DUTY_EN`, `mon_clk` 40 ns at 25% duty → `high_time`=1 each sample. Without the macro → `high_time`=0.
